tp_serial_loader: RTL and testbench
===================================

// Module: tp_serial_loader
//
// PURPOSE
// Receive side of the tiny processor's serial load link. Samples the one-bit data line and the
// 2-bit mode line, and deserialises each 12-bit frame {data[7:0], addr[3:0]}, sent LSB first.
// Each good frame becomes a one-cycle write strobe into instruction or register storage.
// Decodes mode 11 as run enable to the core. Sits at the processor boundary, between the pins
// and the imem/dmem write ports.
//
// PARAMETERS
// ADDR_W      4   frame address bits; storage depth 2**ADDR_W
// DATA_W      8   frame payload bits
// PRE_CYCLES  1   mode-active rising edges before bit 0 is sampled
//
// PORTS
// clk        in   1        system clock; all sampling on rising edge
// rst_n      in   1        reset, asynchronous assert, active low
// mosi_in    in   1        serial data, LSB first, changes on falling edge of clk
// mode_in    in   2        00 idle, 01 imem load, 10 dmem load, 11 run
// wr_en      out  1        one-cycle write strobe
// wr_sel     out  1        0 = imem, 1 = dmem; valid with wr_en
// wr_addr    out  ADDR_W   storage index; valid with wr_en
// wr_data    out  DATA_W   payload; valid with wr_en
// run        out  1        high while in RUN state
// run_start  out  1        one-cycle pulse on entry to RUN
// frame_err  out  1        one-cycle pulse when a frame is discarded
// frame_cnt  out  ADDR_W+1 good frames since last run_start; saturates at 2**ADDR_W
//
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; shift register and frame_cnt cleared.
//   Asynchronous reset mid-frame discards the frame with no wr_en and no frame_err.
// - Frame length: NB = ADDR_W + DATA_W (12 at defaults).
// - bitcnt counts rising edges on which the sampled mode_in is 01 or 10.
//   Edges 1..PRE_CYCLES are preamble. The next NB edges sample bits 0..NB-1.
// - States:
//   IDLE  : mode 01/10 -> PRE (latch mode as frame kind); mode 11 -> RUN; mode 00 -> stay.
//   PRE   : after PRE_CYCLES edges -> SHIFT.
//   SHIFT : shift mosi_in in at the MSB end (right shift), so bit 0 ends at the LSB.
//           After NB samples -> STOP.
//   STOP  : expects mode 00 on the next edge. If also mosi_in == 0 (stop bit): commit, then IDLE.
//           If mode 00 and mosi_in == 1: frame_err, then IDLE.
//           If mode still 01/10 (overrun): frame_err, then DRAIN.
//   DRAIN : wait for mode 00 -> IDLE. No writes.
//   RUN   : run = 1. Mode 00 -> IDLE; 01/10 -> PRE (a new batch load, no frame_err);
//           11 -> stay.
// - Abort: in PRE or SHIFT, mode 00 -> frame_err, then IDLE.
//   In PRE or SHIFT, mode changes between 01 and 10 -> frame_err, then DRAIN.
//   In PRE or SHIFT, mode 11 -> frame_err, then RUN.
// - Commit (registered): on the clock edge after the STOP edge, drive for one cycle:
//     wr_en = 1; wr_sel = latched kind; wr_addr = sr[ADDR_W-1:0]; wr_data = sr[NB-1:ADDR_W].
//   Latency from the last data-bit edge to wr_en high: 2 edges.
//   frame_cnt increments on commit and saturates.
// - run_start is registered on entry to RUN, including entry from an abort.
//   The same edge clears frame_cnt.
//   If entry to RUN and a commit fall on the same edge, the clear wins.
// - Back-to-back frames: the idle edge that ends one frame may be directly followed by
//   mode 01/10 on the next edge. The loader accepts this with no lost frame.
// - wr_addr may repeat; no duplicate check (last write wins downstream).
// - frame_err and wr_en are never high in the same cycle.
//
// STRUCTURE
// - tp_loader_pkg:
//     mode_t enum: MODE_IDLE = 2'b00, MODE_IMEM = 2'b01, MODE_DMEM = 2'b10, MODE_RUN = 2'b11
//     ldr_state_t: IDLE, PRE, SHIFT, STOP, DRAIN, RUN
//     localparams: FRAME_BITS, STOP_BIT_VAL = 1'b0
// - Sub-module tp_loader_shreg: NB-bit shift register with shift_en and clear, plus bitcnt.
//   The top level holds the FSM, commit registers, frame_cnt and error logic.
//
// TESTING
// 1. Mode 01 for 13 edges, mosi frame addr=0x3 data=0xA5, then mode 00 with mosi=0
//    -> single wr_en, wr_sel=0, wr_addr=3, wr_data=A5, frame_cnt=1.
// 2. 16 back-to-back mode-10 frames, addr 0..15, data = addr^0xFF
//    -> 16 dmem writes in order, frame_cnt=16 and holds on a 17th frame.
// 3. Mode 01 dropped to 00 after 6 data bits -> frame_err pulse, no wr_en; next frame accepted.
// 4. Mode held 01 for 14 edges (overrun) -> frame_err, DRAIN until 00, no write.
//    Stop bit = 1 -> frame_err, no write.
// 5. Mode 11 after a load -> run_start 1 cycle, run high, frame_cnt=0.
//    Mode 01 from RUN -> PRE and a new frame committed.
// 6. rst_n low on the 7th shift edge -> outputs 0 asynchronously, no write.
//    Frame after release decodes correctly.

Source files
------------

// File: rtl/tp_loader_pkg.sv
// Shared types and constants for the serial load link receiver.
package tp_loader_pkg;

  // Link mode encoding as seen on the two mode pins.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_IMEM = 2'b01,
    MODE_DMEM = 2'b10,
    MODE_RUN  = 2'b11
  } mode_t;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StShift,
    StStop,
    StDrain,
    StRun
  } ldr_state_t;

  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_PRE_CYCLES = 1;
  localparam int unsigned FRAME_BITS     = DEF_ADDR_W + DEF_DATA_W;
  localparam logic        STOP_BIT_VAL   = 1'b0;

  // True for the two modes that carry frame data.
  function automatic logic is_load(input mode_t m);
    return (m == MODE_IMEM) || (m == MODE_DMEM);
  endfunction

endpackage

// File: rtl/tp_serial_loader_if.sv
// Pin-side link and storage write port of the serial loader.
interface tp_serial_loader_if
  import tp_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              mosi_in;
  logic [1:0]        mode_in;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              run;
  logic              run_start;
  logic              frame_err;
  logic [ADDR_W:0]   frame_cnt;

  // Host side: drives the pins, observes the write port.
  modport master (
    output mosi_in, mode_in,
    input  wr_en, wr_sel, wr_addr, wr_data, run, run_start, frame_err, frame_cnt
  );

  // Loader side.
  modport slave (
    input  mosi_in, mode_in,
    output wr_en, wr_sel, wr_addr, wr_data, run, run_start, frame_err, frame_cnt
  );
endinterface

// File: rtl/tp_loader_shreg.sv
// Frame shift register (right shift, LSB-first arrival) and active-edge counter.
module tp_loader_shreg
  import tp_loader_pkg::*;
#(
  parameter int unsigned Width = FRAME_BITS,
  parameter int unsigned CntW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic             cnt_inc_i,
  output logic [Width-1:0] sr_o,
  output logic [CntW-1:0]  bitcnt_o
);
  logic [Width-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;

  // Clear on frame start; the start edge itself is counted, so clear+inc loads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (clear_i) begin
        sr_q <= '0;
      end else if (shift_en_i) begin
        sr_q <= {bit_i, sr_q[Width-1:1]};
      end
      if (clear_i) begin
        cnt_q <= cnt_inc_i ? CntW'(1) : '0;
      end else if (cnt_inc_i) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign sr_o     = sr_q;
  assign bitcnt_o = cnt_q;
endmodule

// File: rtl/tp_serial_loader.sv
// Serial load link receiver: frame FSM, registered commit, frame counter and error pulses.
// PRE_CYCLES must be at least 1: the edge that leaves IDLE/RUN is always a preamble edge.
module tp_serial_loader
  import tp_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned PRE_CYCLES = DEF_PRE_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  tp_serial_loader_if.slave link_io
);
  localparam int unsigned NB   = ADDR_W + DATA_W;
  localparam int unsigned CntW = $clog2(PRE_CYCLES + NB + 1);
  localparam int unsigned FcnW = ADDR_W + 1;

  localparam logic [CntW-1:0] PreCnt  = CntW'(PRE_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(PRE_CYCLES + NB - 1);
  localparam logic [FcnW-1:0] FcnMax  = {1'b1, {ADDR_W{1'b0}}};

  ldr_state_t        state_q;
  logic              kind_q;   // 0 = imem frame, 1 = dmem frame
  logic              pend_q;   // stop bit accepted, write goes out next edge
  logic              wr_en_q;
  logic              wr_sel_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              run_q;
  logic              run_start_q;
  logic              frame_err_q;
  logic [FcnW-1:0]   frame_cnt_q;

  mode_t           mode;
  logic            mode_load;
  logic            mode_dmem;
  logic            same_kind;
  logic            sr_clear;
  logic            sr_shift;
  logic            cnt_inc;
  logic [NB-1:0]   sr;
  logic [CntW-1:0] bitcnt;

  assign mode      = mode_t'(link_io.mode_in);
  assign mode_load = is_load(mode);
  assign mode_dmem = (mode == MODE_DMEM);
  assign same_kind = mode_load && (mode_dmem == kind_q);

  tp_loader_shreg #(
    .Width (NB),
    .CntW  (CntW)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (sr_clear),
    .shift_en_i (sr_shift),
    .bit_i      (link_io.mosi_in),
    .cnt_inc_i  (cnt_inc),
    .sr_o       (sr),
    .bitcnt_o   (bitcnt)
  );

  // Shift register control: start a frame from IDLE/RUN, sample data bits in PRE/SHIFT.
  always_comb begin
    sr_clear = 1'b0;
    sr_shift = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (mode_load) begin
          sr_clear = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      StPre: begin
        if (same_kind) begin
          cnt_inc  = 1'b1;
          sr_shift = (bitcnt == PreCnt);
        end
      end
      StShift: begin
        if (same_kind) begin
          cnt_inc  = 1'b1;
          sr_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame FSM with registered strobes; later assignments override the per-cycle defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      kind_q      <= 1'b0;
      pend_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      run_q       <= 1'b0;
      run_start_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      pend_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      run_q       <= 1'b0;
      run_start_q <= 1'b0;
      frame_err_q <= 1'b0;

      // sr and kind_q still hold the committed frame here even if a new frame starts now.
      if (pend_q) begin
        wr_en_q   <= 1'b1;
        wr_sel_q  <= kind_q;
        wr_addr_q <= sr[ADDR_W-1:0];
        wr_data_q <= sr[NB-1:ADDR_W];
        if (frame_cnt_q != FcnMax) begin
          frame_cnt_q <= frame_cnt_q + FcnW'(1);
        end
      end

      case (state_q)
        StIdle: begin
          if (mode == MODE_RUN) begin
            state_q     <= StRun;
            run_q       <= 1'b1;
            run_start_q <= 1'b1;
            frame_cnt_q <= '0;
          end else if (mode_load) begin
            state_q <= StPre;
            kind_q  <= mode_dmem;
          end
        end
        StPre, StShift: begin
          if (mode == MODE_IDLE) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end else if (mode == MODE_RUN) begin
            frame_err_q <= 1'b1;
            state_q     <= StRun;
            run_q       <= 1'b1;
            run_start_q <= 1'b1;
            frame_cnt_q <= '0;
          end else if (!same_kind) begin
            frame_err_q <= 1'b1;
            state_q     <= StDrain;
          end else if (state_q == StPre) begin
            if (bitcnt == PreCnt) begin
              state_q <= StShift;
            end
          end else if (bitcnt == LastCnt) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          if (mode == MODE_IDLE) begin
            if (link_io.mosi_in == STOP_BIT_VAL) begin
              pend_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= StIdle;
          end else if (mode == MODE_RUN) begin
            frame_err_q <= 1'b1;
            state_q     <= StRun;
            run_q       <= 1'b1;
            run_start_q <= 1'b1;
            frame_cnt_q <= '0;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (mode == MODE_IDLE) begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (mode == MODE_RUN) begin
            run_q <= 1'b1;
          end else if (mode_load) begin
            state_q <= StPre;
            kind_q  <= mode_dmem;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign link_io.wr_en     = wr_en_q;
  assign link_io.wr_sel    = wr_sel_q;
  assign link_io.wr_addr   = wr_addr_q;
  assign link_io.wr_data   = wr_data_q;
  assign link_io.run       = run_q;
  assign link_io.run_start = run_start_q;
  assign link_io.frame_err = frame_err_q;
  assign link_io.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_tp_serial_loader.sv
// Directed + randomized bench for tp_serial_loader with a transaction-level reference model.
module tb_tp_serial_loader;
  import tp_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference model: expected writes, frame count, error and run_start pulse totals.
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  int exp_cnt = 0;
  int exp_err = 0;
  int exp_rs  = 0;
  int obs_err = 0;
  int obs_rs  = 0;
  int overlap = 0;

  tp_serial_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  tp_serial_loader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .PRE_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .link_io (bus)
  );

  always #5 clk = ~clk;

  // Monitor just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.wr_en) obs_q.push_back({bus.wr_sel, bus.wr_addr, bus.wr_data});
    if (bus.frame_err) obs_err++;
    if (bus.run_start) obs_rs++;
    if (bus.wr_en && bus.frame_err) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply pins at a falling edge; return at the next falling edge.
  task automatic drive(input logic [1:0] m, input logic b);
    bus.mode_in = m;
    bus.mosi_in = b;
    @(negedge clk);
  endtask

  task automatic count_good();
    exp_cnt = (exp_cnt < 16) ? exp_cnt + 1 : 16;
  endtask

  task automatic send_head(input logic [1:0] kind, input logic [11:0] f, input int nbits);
    drive(kind, 1'($urandom));
    for (int i = 0; i < nbits; i++) drive(kind, f[i]);
  endtask

  task automatic send_frame(input logic [1:0] kind, input logic [3:0] addr,
                            input logic [7:0] data, input logic stopb);
    send_head(kind, {data, addr}, 12);
    drive(2'b00, stopb);
    if (stopb == 1'b0) begin
      exp_q.push_back({kind == 2'b10, addr, data});
      count_good();
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, " write count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s write %0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [1:0]  kind;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [11:0] f;
    int          k;

    bus.mode_in = 2'b00;
    bus.mosi_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset wr_en", bus.wr_en, 0);
    check("reset run", bus.run, 0);
    check("reset run_start", bus.run_start, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset frame_cnt", bus.frame_cnt, 0);
    check("reset wr_addr/data", {bus.wr_sel, bus.wr_addr, bus.wr_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: single imem frame, exact commit latency and one-cycle strobe.
    send_frame(2'b01, 4'h3, 8'hA5, 1'b0);
    check("t1 wr_en after stop edge", bus.wr_en, 0);
    drive(2'b00, 1'b0);
    check("t1 wr_en", bus.wr_en, 1);
    check("t1 fields", {bus.wr_sel, bus.wr_addr, bus.wr_data}, {1'b0, 4'h3, 8'hA5});
    check("t1 frame_cnt", bus.frame_cnt, exp_cnt);
    drive(2'b00, 1'b0);
    check("t1 wr_en one cycle", bus.wr_en, 0);
    check_writes("t1");

    // T2: clear via run, 16 back-to-back dmem frames, then saturation on the 17th.
    drive(2'b11, 1'b0);
    exp_rs++;
    exp_cnt = 0;
    check("t2 run_start", bus.run_start, 1);
    check("t2 frame_cnt cleared", bus.frame_cnt, 0);
    drive(2'b00, 1'b0);
    for (int i = 0; i < 16; i++) send_frame(2'b10, 4'(i), 8'(i) ^ 8'hFF, 1'b0);
    drive(2'b00, 1'b0);
    check("t2 frame_cnt 16", bus.frame_cnt, exp_cnt);
    send_frame(2'b10, 4'($urandom), 8'($urandom), 1'b0);
    drive(2'b00, 1'b0);
    check("t2 frame_cnt saturated", bus.frame_cnt, 16);
    check_writes("t2");

    // T3/T4: early drop, overrun with drain, bad stop bit; then a good frame.
    send_head(2'b01, 12'h5C3, 6);
    drive(2'b00, 1'b0);
    exp_err++;
    check("t3 frame_err", bus.frame_err, 1);
    check("t3 no write", bus.wr_en, 0);
    send_head(2'b01, 12'h1E7, 12);
    drive(2'b01, 1'b0);
    exp_err++;
    check("t4 overrun frame_err", bus.frame_err, 1);
    repeat (3) drive(2'b01, 1'b0);
    drive(2'b00, 1'b0);
    send_frame(2'b01, 4'h7, 8'h42, 1'b1);
    send_frame(2'b01, 4'hC, 8'h99, 1'b0);
    drive(2'b00, 1'b0);
    check_writes("t3t4");
    check("t3t4 frame_err total", obs_err, exp_err);

    // T5: run entry on the commit edge (clear wins), load from RUN, abort into RUN.
    send_frame(2'b10, 4'hA, 8'h5A, 1'b0);
    drive(2'b11, 1'b0);
    exp_rs++;
    exp_cnt = 0;
    check("t5 wr_en at run entry", bus.wr_en, 1);
    check("t5 run_start", bus.run_start, 1);
    check("t5 frame_cnt clear wins", bus.frame_cnt, 0);
    drive(2'b11, 1'b0);
    check("t5 run held", bus.run, 1);
    check("t5 run_start one cycle", bus.run_start, 0);
    send_frame(2'b01, 4'h2, 8'hC7, 1'b0);
    check("t5 run dropped", bus.run, 0);
    drive(2'b00, 1'b0);
    check("t5 frame_cnt", bus.frame_cnt, exp_cnt);
    send_head(2'b10, 12'h0F0, 5);
    drive(2'b11, 1'b0);
    exp_err++;
    exp_rs++;
    exp_cnt = 0;
    check("t5 abort err+run_start", {bus.frame_err, bus.run_start, bus.run}, 3'b111);
    drive(2'b00, 1'b0);
    check_writes("t5");

    // T6: asynchronous reset on the 7th shift edge, then a clean frame.
    send_frame(2'b01, 4'h9, 8'h3C, 1'b0);
    drive(2'b00, 1'b0);
    check_writes("t6 pre");
    f = 12'hB6D;
    send_head(2'b01, f, 6);
    bus.mode_in = 2'b01;
    bus.mosi_in = f[6];
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6 async clear", {bus.wr_addr, bus.wr_data, bus.frame_cnt, bus.run}, 0);
    exp_cnt = 0;
    @(negedge clk);
    bus.mode_in = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(2'b10, 4'hE, 8'h81, 1'b0);
    drive(2'b00, 1'b0);
    check("t6 frame_cnt", bus.frame_cnt, exp_cnt);
    check_writes("t6");

    // Randomized mix of good and faulty frames, sometimes back-to-back.
    for (int n = 0; n < 40; n++) begin
      kind = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a = 4'($urandom);
      d = 8'($urandom);
      f = {d, a};
      case ($urandom_range(0, 6))
        3: send_frame(kind, a, d, 1'b1);
        4: begin
          k = $urandom_range(0, 11);
          send_head(kind, f, k);
          drive(2'b00, 1'b0);
          exp_err++;
        end
        5: begin
          send_head(kind, f, 12);
          drive(kind, 1'($urandom));
          repeat ($urandom_range(0, 2)) drive(kind, 1'($urandom));
          drive(2'b00, 1'b0);
          exp_err++;
        end
        6: begin
          k = $urandom_range(0, 11);
          send_head(kind, f, k);
          drive(kind ^ 2'b11, 1'b0);
          drive(2'b00, 1'b0);
          exp_err++;
        end
        default: send_frame(kind, a, d, 1'b0);
      endcase
      repeat ($urandom_range(0, 1)) drive(2'b00, 1'($urandom));
    end
    drive(2'b00, 1'b0);
    drive(2'b00, 1'b0);
    check("rand frame_cnt", bus.frame_cnt, exp_cnt);
    check_writes("rand");
    check("total frame_err", obs_err, exp_err);
    check("total run_start", obs_rs, exp_rs);
    check("wr_en/frame_err overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
